// File: rtl/uart_inst_loader.sv
// UART (8N1) instruction loader: assembles little-endian 32-bit words into ICCM writes.
// Define UART_LOADER_MAJORITY_VOTE_EN for 2-of-3 majority sampling of each bit.
module uart_inst_loader #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter int          ADDR_W       = 12,
    parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_inst,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              load_done_o,
    output logic              frame_err_o,
    output logic              overrun_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [1:0]         dly_q, dly_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [1:0]         idx_q, idx_d;
    logic [23:0]        word_q, word_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               done_q, done_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
    logic               rx, rx_s, fall, byte_ok;
    logic [31:0]        full_word;

    // dly_q[0] is the centre tap so the vote can see one cycle either side
    // without shifting the sample point between build variants.
    assign rx   = sync_q[1];
    assign fall = dly_q[1] & ~dly_q[0];
`ifdef UART_LOADER_MAJORITY_VOTE_EN
    assign rx_s = (dly_q[1] & dly_q[0]) | (dly_q[1] & rx) | (dly_q[0] & rx);
`else
    assign rx_s = dly_q[0];
`endif

    assign sync_d = {sync_q[0], uart_rx_inst};
    assign dly_d  = {dly_q[0], rx};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            dly_q   <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (fall) state_d = START;
            START: if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
            DATA:  if (cnt_q == LAST && bit_q == 3'd7) state_d = STOP;
            STOP:  if (cnt_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        byte_ok = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
            end
            START: if (cnt_q == HALF) cnt_d = '0;
            DATA: if (cnt_q == LAST) begin
                cnt_d   = '0;
                shreg_d = {rx_s, shreg_q[7:1]};
                bit_d   = bit_q + 1'b1;
            end
            STOP: if (cnt_q == LAST) begin
                cnt_d   = '0;
                byte_ok = rx_s;
                ferr_d  = ~rx_s;
            end
            default: cnt_d = '0;
        endcase
    end

    assign full_word = {shreg_q, word_q};

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        // Grant retires first so a word landing on the grant cycle is accepted.
        if (req_q && mem_gnt_i) begin
            req_d  = 1'b0;
            addr_d = addr_q + 1'b1;
        end
        if (byte_ok && !done_q) begin
            idx_d = idx_q + 1'b1;
            unique case (idx_q)
                2'd0: word_d[7:0]   = shreg_q;
                2'd1: word_d[15:8]  = shreg_q;
                2'd2: word_d[23:16] = shreg_q;
                default: begin
                    if (full_word == END_WORD) begin
                        done_d = 1'b1;
                    end else if (req_d) begin
                        ovr_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        wdata_d = full_word;
                    end
                end
            endcase
        end
    end

    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign load_done_o = done_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader at CLKS_PER_BIT=16.
// Expected writes are queued as words are sent and popped on each granted request.
module tb_uart_inst_loader;

    localparam int CPB = 16;
    localparam int AW  = 12;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          uart_rx_inst = 1'b1;
    logic          mem_req_o;
    logic          mem_gnt_i = 1'b1;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          load_done_o;
    logic          frame_err_o;
    logic          overrun_o;

    int n_chk  = 0;
    int n_pass = 0;
    int fe_cnt = 0;
    int req_in_done = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    uart_inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .uart_rx_inst (uart_rx_inst),
        .mem_req_o    (mem_req_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .load_done_o  (load_done_o),
        .frame_err_o  (frame_err_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (frame_err_o) fe_cnt++;
            if (load_done_o && mem_req_o) req_in_done++;
            if (mem_req_o && mem_gnt_i) begin
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", mem_wdata_o, 32'hx);
                end else begin
                    check("wr_addr", 32'(mem_addr_o), exp_addr.pop_front());
                    check("wr_data", mem_wdata_o, exp_data.pop_front());
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        uart_rx_inst = 1'b1;
        mem_gnt_i = 1'b1;
        cycles(3);
        rst_i = 1'b0;
        cycles(4);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        uart_rx_inst = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_inst = b[i];
            cycles(CPB);
        end
        uart_rx_inst = stop_v;
        cycles(CPB);
        uart_rx_inst = 1'b1;
        cycles(CPB);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    initial begin
        int fe0, rd0;

        // reset values
        cycles(3);
        check("rst_req", 32'(mem_req_o), 0);
        check("rst_addr", 32'(mem_addr_o), 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_done", 32'(load_done_o), 0);
        check("rst_ferr", 32'(frame_err_o), 0);
        check("rst_ovr", 32'(overrun_o), 0);
        rst_i = 1'b0;
        cycles(4);

        // single word
        expect_wr(0, 32'h0020_0113);
        send_word(32'h0020_0113);
        cycles(8);
        check("w1_addr_after", 32'(mem_addr_o), 1);
        check("w1_sb_empty", 32'(exp_addr.size()), 0);

        // two words then terminator
        do_reset();
        expect_wr(0, 32'h0020_0113);
        expect_wr(1, 32'h0000_0093);
        send_word(32'h0020_0113);
        send_word(32'h0000_0093);
        send_word(32'hFFFF_FFFF);
        cycles(4);
        check("term_done", 32'(load_done_o), 1);
        check("term_addr", 32'(mem_addr_o), 2);
        check("term_sb_empty", 32'(exp_addr.size()), 0);
        rd0 = req_in_done;
        send_word(32'h1234_5678);
        cycles(4);
        check("term_no_req", 32'(req_in_done - rd0), 0);
        check("term_addr_hold", 32'(mem_addr_o), 2);
        check("term_done_sticky", 32'(load_done_o), 1);

        // frame error then good word
        do_reset();
        fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        cycles(CPB);
        check("ferr_one_pulse", 32'(fe_cnt - fe0), 1);
        expect_wr(0, 32'h0020_0113);
        send_word(32'h0020_0113);
        cycles(4);
        check("ferr_sb_empty", 32'(exp_addr.size()), 0);
        check("ferr_addr", 32'(mem_addr_o), 1);

        // false start glitch
        do_reset();
        fe0 = fe_cnt;
        uart_rx_inst = 1'b0;
        cycles(5);
        uart_rx_inst = 1'b1;
        cycles(2 * CPB);
        check("glitch_no_ferr", 32'(fe_cnt - fe0), 0);
        check("glitch_no_req", 32'(mem_req_o), 0);
        expect_wr(0, 32'h0000_0093);
        send_word(32'h0000_0093);
        cycles(4);
        check("glitch_sb_empty", 32'(exp_addr.size()), 0);

        // overrun with grant withheld
        do_reset();
        mem_gnt_i = 1'b0;
        expect_wr(0, 32'h1122_3344);
        send_word(32'h1122_3344);
        send_word(32'hAABB_CCDD);
        cycles(2);
        check("ovr_flag", 32'(overrun_o), 1);
        check("ovr_req_held", 32'(mem_req_o), 1);
        check("ovr_addr_held", 32'(mem_addr_o), 0);
        check("ovr_data_held", mem_wdata_o, 32'h1122_3344);
        mem_gnt_i = 1'b1;
        cycles(6);
        check("ovr_req_drop", 32'(mem_req_o), 0);
        check("ovr_addr_after", 32'(mem_addr_o), 1);
        check("ovr_sb_empty", 32'(exp_addr.size()), 0);

        // reset after a partial word
        do_reset();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        rst_i = 1'b1;
        cycles(2);
        check("mid_rst_req", 32'(mem_req_o), 0);
        check("mid_rst_addr", 32'(mem_addr_o), 0);
        check("mid_rst_ovr", 32'(overrun_o), 0);
        rst_i = 1'b0;
        cycles(4);
        expect_wr(0, 32'h0020_0113);
        send_word(32'h0020_0113);
        cycles(4);
        check("mid_rst_sb_empty", 32'(exp_addr.size()), 0);
        check("mid_rst_addr_after", 32'(mem_addr_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
